// File: rtl/cnn_mul_share_arb_if.sv
// Handshake bundle for cnn_mul_share_arb.
// Carries the requester term channels (valid/ready/a/b/last), the shared multiplier
// operand/product wires and the result channel (valid/ready/data/id).
// slave  : the arbiter side (consumes terms and products, produces results and operands).
// master : the environment side (requesters, external multiplier and result consumer).
interface cnn_mul_share_arb_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned A_W     = 9,
  parameter int unsigned B_W     = 14,
  parameter int unsigned P_W     = 23,
  parameter int unsigned ACC_W   = 32
);

  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic [NUM_REQ-1:0]     req_last;

  logic [A_W-1:0]         mul_din0;
  logic [B_W-1:0]         mul_din1;
  logic [P_W-1:0]         mul_dout;

  logic                   res_valid;
  logic                   res_ready;
  logic [ACC_W-1:0]       res_data;
  logic [IDX_W-1:0]       res_id;

  modport slave (
    input  req_valid, req_a, req_b, req_last, mul_dout, res_ready,
    output req_ready, mul_din0, mul_din1, res_valid, res_data, res_id
  );

  modport master (
    output req_valid, req_a, req_b, req_last, mul_dout, res_ready,
    input  req_ready, mul_din0, mul_din1, res_valid, res_data, res_id
  );

endinterface

// File: rtl/cnn_mul_share_arb.sv
// Shares one external signed A_W x B_W combinational multiplier among NUM_REQ dot-product
// requesters. A round-robin arbiter accepts at most one term per cycle into an operand
// register (S1) that drives the multiplier; on the following edge the product is added to
// the requester's accumulator. A term flagged last emits the finished sum with its id.
//
// Ports:
//   ap_clk  - clock, all state on the rising edge
//   ap_rst  - synchronous active-high reset
//   bus     - cnn_mul_share_arb_if.slave:
//               req_valid/req_ready/req_a/req_b/req_last : per-requester term channel
//               mul_din0/mul_din1 -> mul_dout            : shared multiplier
//               res_valid/res_ready/res_data/res_id      : result channel
module cnn_mul_share_arb #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned A_W     = 9,
  parameter int unsigned B_W     = 14,
  parameter int unsigned P_W     = 23,
  parameter int unsigned ACC_W   = 32
) (
  input  logic                ap_clk,
  input  logic                ap_rst,
  cnn_mul_share_arb_if.slave  bus
);

  // Result slot holds an unconsumed sum: freeze the whole pipeline.
  logic               stall;

  logic               grant_vld;
  logic [IDX_W-1:0]   grant_id;
  logic [IDX_W-1:0]   cand;
  logic [NUM_REQ-1:0] req_ready;

  logic               s1_valid_q, s1_valid_d;
  logic [A_W-1:0]     s1_a_q, s1_a_d;
  logic [B_W-1:0]     s1_b_q, s1_b_d;
  logic               s1_last_q, s1_last_d;
  logic [IDX_W-1:0]   s1_id_q, s1_id_d;

  // Index of the most recently granted requester; search starts just after it.
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  logic [ACC_W-1:0]   acc_q [NUM_REQ];
  logic [ACC_W-1:0]   acc_d [NUM_REQ];

  logic               res_valid_q, res_valid_d;
  logic [ACC_W-1:0]   res_data_q, res_data_d;
  logic [IDX_W-1:0]   res_id_q, res_id_d;

  logic [ACC_W-1:0]   prod_ext;
  logic [ACC_W-1:0]   sum;

  assign stall = res_valid_q & ~bus.res_ready;

  // Round-robin search ptr+1, ptr+2, ... modulo NUM_REQ; first valid requester wins.
  // No grant while reset is asserted so a requester never sees a handshake that reset drops.
  always_comb begin
    grant_vld = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = IDX_W'((32'(ptr_q) + off) % NUM_REQ);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_id  = cand;
      end
    end
    if (stall || ap_rst) begin
      grant_vld = 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (grant_vld) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign bus.req_ready = req_ready;

  // Operands are zeroed while S1 is empty so the multiplier input stays quiet.
  assign bus.mul_din0 = s1_valid_q ? s1_a_q : '0;
  assign bus.mul_din1 = s1_valid_q ? s1_b_q : '0;

  // Size cast of a signed value sign-extends the product to the accumulator width.
  assign prod_ext = ACC_W'($signed(bus.mul_dout));
  assign sum      = acc_q[s1_id_q] + prod_ext;

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_a_d      = s1_a_q;
    s1_b_d      = s1_b_q;
    s1_last_d   = s1_last_q;
    s1_id_d     = s1_id_q;
    ptr_d       = ptr_q;
    acc_d       = acc_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;

    if (!stall) begin
      // Operand capture for the granted requester.
      s1_valid_d = grant_vld;
      if (grant_vld) begin
        s1_a_d    = bus.req_a[grant_id*A_W +: A_W];
        s1_b_d    = bus.req_b[grant_id*B_W +: B_W];
        s1_last_d = bus.req_last[grant_id];
        s1_id_d   = grant_id;
        ptr_d     = grant_id;
      end

      // Not stalled means the result slot is empty or being consumed this edge.
      res_valid_d = 1'b0;

      // Accumulate; a last term retires the sum and clears the accumulator.
      if (s1_valid_q) begin
        if (s1_last_q) begin
          acc_d[s1_id_q] = '0;
          res_valid_d    = 1'b1;
          res_data_d     = sum;
          res_id_d       = s1_id_q;
        end else begin
          acc_d[s1_id_q] = sum;
        end
      end
    end
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      s1_valid_q  <= 1'b0;
      s1_a_q      <= '0;
      s1_b_q      <= '0;
      s1_last_q   <= 1'b0;
      s1_id_q     <= '0;
      ptr_q       <= IDX_W'(NUM_REQ - 1);
      for (int i = 0; i < NUM_REQ; i++) begin
        acc_q[i] <= '0;
      end
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_a_q      <= s1_a_d;
      s1_b_q      <= s1_b_d;
      s1_last_q   <= s1_last_d;
      s1_id_q     <= s1_id_d;
      ptr_q       <= ptr_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        acc_q[i] <= acc_d[i];
      end
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
    end
  end

  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;

endmodule

// File: tb/tb_cnn_mul_share_arb.sv
module tb_cnn_mul_share_arb;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned IDX_W   = 2;
  localparam int unsigned A_W     = 9;
  localparam int unsigned B_W     = 14;
  localparam int unsigned P_W     = 23;
  localparam int unsigned ACC_W   = 32;

  logic ap_clk = 1'b0;
  logic ap_rst;
  int   checks = 0;
  int   errors = 0;

  always #5 ap_clk = ~ap_clk;

  cnn_mul_share_arb_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .A_W(A_W), .B_W(B_W), .P_W(P_W),
                         .ACC_W(ACC_W)) bus ();
  cnn_mul_share_arb_if #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .A_W(A_W), .B_W(B_W), .P_W(P_W),
                         .ACC_W(24)) bus24 ();

  cnn_mul_share_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .A_W(A_W), .B_W(B_W), .P_W(P_W),
                      .ACC_W(ACC_W)) u_dut (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus)
  );

  cnn_mul_share_arb #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W), .A_W(A_W), .B_W(B_W), .P_W(P_W),
                      .ACC_W(24)) u_dut24 (
    .ap_clk (ap_clk),
    .ap_rst (ap_rst),
    .bus    (bus24)
  );

  // External combinational multipliers.
  logic signed [P_W-1:0] ma, mb, ma24, mb24;
  assign ma = {{(P_W-A_W){bus.mul_din0[A_W-1]}}, bus.mul_din0};
  assign mb = {{(P_W-B_W){bus.mul_din1[B_W-1]}}, bus.mul_din1};
  assign bus.mul_dout = ma * mb;
  assign ma24 = {{(P_W-A_W){bus24.mul_din0[A_W-1]}}, bus24.mul_din0};
  assign mb24 = {{(P_W-B_W){bus24.mul_din1[B_W-1]}}, bus24.mul_din1};
  assign bus24.mul_dout = ma24 * mb24;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    bit                rst;
    logic [3:0]        vld;
    logic [3:0]        last;
    logic [3:0][8:0]   a;
    logic [3:0][13:0]  b;
    bit                rdy;
    logic [3:0]        exp_ready;
    bit                exp_rv;
    int                exp_id;
    int                exp_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t row(bit rst, logic [3:0] vld, logic [3:0] last,
                               int a0, int a1, int a2, int a3, int b0, int b1, int b2, int b3,
                               bit rdy, logic [3:0] er, bit erv, int eid, int edata);
    vec_t v;
    v.rst = rst; v.vld = vld; v.last = last;
    v.a[0] = 9'(a0);  v.a[1] = 9'(a1);  v.a[2] = 9'(a2);  v.a[3] = 9'(a3);
    v.b[0] = 14'(b0); v.b[1] = 14'(b1); v.b[2] = 14'(b2); v.b[3] = 14'(b3);
    v.rdy = rdy; v.exp_ready = er; v.exp_rv = erv; v.exp_id = eid; v.exp_data = edata;
    return v;
  endfunction

  function automatic vec_t idle(bit rst, bit rdy, logic [3:0] er, bit erv, int eid, int edata);
    return row(rst, 4'b0, 4'b0, 0, 0, 0, 0, 0, 0, 0, 0, rdy, er, erv, eid, edata);
  endfunction

  task automatic set_req(input int i, input int a, input int b, input bit l);
    bus.req_a[i*A_W +: A_W] = A_W'(a);
    bus.req_b[i*B_W +: B_W] = B_W'(b);
    bus.req_last[i]         = l;
  endtask

  // Reference model state for the random phase.
  longint     m_acc [NUM_REQ];
  bit         m_pend_valid;
  int         m_pend_id;
  longint     m_pend_prod;
  bit         m_pend_last;
  bit         m_res_valid;
  longint     m_res_sum;
  int         m_res_id;
  int         m_last;
  logic [3:0] r_vld;
  logic [3:0] r_last;
  logic [A_W-1:0] r_a [NUM_REQ];
  logic [B_W-1:0] r_b [NUM_REQ];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         got;
    bit         stall;
    int         gnt;
    logic [3:0] er;
    logic [31:0] w32;
    logic [23:0] w24;
    longint     s24;

    ap_rst          = 1'b1;
    bus.req_valid   = '0; bus.req_a = '0; bus.req_b = '0; bus.req_last = '0; bus.res_ready = 1'b1;
    bus24.req_valid = '0; bus24.req_a = '0; bus24.req_b = '0; bus24.req_last = '0;
    bus24.res_ready = 1'b1;
    repeat (2) @(posedge ap_clk);
    #1 ap_rst = 1'b0;

    // Reset state.
    @(negedge ap_clk);
    chk("reset res_valid", longint'(bus.res_valid), 0);
    chk("reset res_data", longint'(bus.res_data), 0);
    chk("reset res_id", longint'(bus.res_id), 0);
    chk("reset req_ready", longint'(bus.req_ready), 0);
    chk("reset mul_din0", longint'(bus.mul_din0), 0);
    chk("reset mul_din1", longint'(bus.mul_din1), 0);
    @(posedge ap_clk); #1;

    // Single-term product with extreme operands.
    vecs.push_back(row(0, 4'b0001, 4'b0001, -256, 0, 0, 0, 8191, 0, 0, 0, 1, 4'b0001, 0, 0, 0));
    vecs.push_back(idle(0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(idle(0, 1, 4'b0000, 1, 0, -2096896));
    // Three-term product on requester 1.
    vecs.push_back(row(0, 4'b0010, 4'b0000, 0, 3, 0, 0, 0, 4, 0, 0, 1, 4'b0010, 0, 0, 0));
    vecs.push_back(row(0, 4'b0010, 4'b0000, 0, -5, 0, 0, 0, 6, 0, 0, 1, 4'b0010, 0, 0, 0));
    vecs.push_back(row(0, 4'b0010, 4'b0010, 0, 7, 0, 0, 0, -8, 0, 0, 1, 4'b0010, 0, 0, 0));
    vecs.push_back(idle(0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(idle(0, 1, 4'b0000, 1, 1, -74));
    vecs.push_back(idle(1, 1, 4'b0000, 0, 0, 0));
    // All requesters, single-term products, one result per cycle in grant order.
    vecs.push_back(row(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 5, 6, 7, 8, 1, 4'b0001, 0, 0, 0));
    vecs.push_back(row(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 5, 6, 7, 8, 1, 4'b0010, 0, 0, 0));
    vecs.push_back(row(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 5, 6, 7, 8, 1, 4'b0100, 1, 0, 5));
    vecs.push_back(row(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 5, 6, 7, 8, 1, 4'b1000, 1, 1, 12));
    vecs.push_back(row(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 5, 6, 7, 8, 1, 4'b0001, 1, 2, 21));
    vecs.push_back(row(0, 4'b1111, 4'b1111, 1, 2, 3, 4, 5, 6, 7, 8, 1, 4'b0010, 1, 3, 32));
    vecs.push_back(idle(0, 1, 4'b0000, 1, 0, 5));
    vecs.push_back(idle(0, 1, 4'b0000, 1, 1, 12));
    // Interleaved three-term products on requesters 0 and 1.
    for (int k = 0; k < 4; k++) begin
      vecs.push_back(row(0, 4'b0011, 4'b0000, 10, -2, 0, 0, 10, 100, 0, 0, 1,
                         (k % 2 == 0) ? 4'b0001 : 4'b0010, 0, 0, 0));
    end
    vecs.push_back(row(0, 4'b0011, 4'b0001, 10, -2, 0, 0, 10, 100, 0, 0, 1, 4'b0001, 0, 0, 0));
    vecs.push_back(row(0, 4'b0010, 4'b0010, 10, -2, 0, 0, 10, 100, 0, 0, 1, 4'b0010, 0, 0, 0));
    vecs.push_back(idle(0, 1, 4'b0000, 1, 0, 300));
    vecs.push_back(idle(0, 1, 4'b0000, 1, 1, -600));
    // Result back-pressure while requester 2 streams two 2-term products.
    vecs.push_back(row(0, 4'b0100, 4'b0000, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4'b0100, 0, 0, 0));
    vecs.push_back(row(0, 4'b0100, 4'b0100, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4'b0100, 0, 0, 0));
    vecs.push_back(row(0, 4'b0100, 4'b0000, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4'b0100, 0, 0, 0));
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(row(0, 4'b0100, 4'b0100, 0, 0, 1, 0, 0, 0, 1, 0, 0, 4'b0000, 1, 2, 2));
    end
    vecs.push_back(row(0, 4'b0100, 4'b0100, 0, 0, 1, 0, 0, 0, 1, 0, 1, 4'b0100, 1, 2, 2));
    vecs.push_back(idle(0, 1, 4'b0000, 0, 0, 0));
    vecs.push_back(idle(0, 1, 4'b0000, 1, 2, 2));
    vecs.push_back(idle(0, 1, 4'b0000, 0, 0, 0));

    foreach (vecs[k]) begin
      ap_rst        = vecs[k].rst;
      bus.req_valid = vecs[k].vld;
      bus.req_last  = vecs[k].last;
      for (int i = 0; i < NUM_REQ; i++) begin
        bus.req_a[i*A_W +: A_W] = vecs[k].a[i];
        bus.req_b[i*B_W +: B_W] = vecs[k].b[i];
      end
      bus.res_ready = vecs[k].rdy;
      @(negedge ap_clk);
      chk($sformatf("vec%0d req_ready", k), longint'(bus.req_ready),
          longint'(vecs[k].exp_ready));
      chk($sformatf("vec%0d res_valid", k), longint'(bus.res_valid), longint'(vecs[k].exp_rv));
      if (vecs[k].exp_rv) begin
        chk($sformatf("vec%0d res_data", k), longint'($signed(bus.res_data)),
            longint'(vecs[k].exp_data));
        chk($sformatf("vec%0d res_id", k), longint'(bus.res_id), longint'(vecs[k].exp_id));
      end
      @(posedge ap_clk); #1;
    end
    ap_rst = 1'b0;

    // Reset mid-stream discards requester 3's partial sum.
    bus.res_ready = 1'b1;
    set_req(3, 100, 100, 1'b0);
    bus.req_valid = 4'b1000;
    for (int k = 0; k < 2; k++) begin
      @(negedge ap_clk);
      chk($sformatf("rst_mid ready%0d", k), longint'(bus.req_ready), 8);
      @(posedge ap_clk); #1;
    end
    bus.req_valid = '0;
    ap_rst        = 1'b1;
    @(negedge ap_clk);
    chk("rst_mid ready during reset", longint'(bus.req_ready), 0);
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    set_req(3, 2, 3, 1'b1);
    bus.req_valid = 4'b1000;
    @(negedge ap_clk);
    chk("rst_mid ready after reset", longint'(bus.req_ready), 8);
    @(posedge ap_clk); #1;
    bus.req_valid = '0;
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge ap_clk);
      if (bus.res_valid) got = 1'b1;
      else begin
        @(posedge ap_clk); #1;
      end
    end
    chk("rst_mid result seen", longint'(got), 1);
    if (got) begin
      chk("rst_mid res_data", longint'($signed(bus.res_data)), 6);
      chk("rst_mid res_id", longint'(bus.res_id), 3);
      @(posedge ap_clk); #1;
    end

    // 24-bit accumulator wraps without saturation.
    s24 = 0;
    bus24.req_a[A_W-1:0] = A_W'(-256);
    bus24.req_b[B_W-1:0] = B_W'(-8192);
    for (int k = 0; k < 5; k++) begin
      bus24.req_valid   = 4'b0001;
      bus24.req_last[0] = (k == 4);
      s24 += 64'sd2097152;
      @(negedge ap_clk);
      chk($sformatf("wrap ready%0d", k), longint'(bus24.req_ready), 1);
      @(posedge ap_clk); #1;
    end
    bus24.req_valid = '0;
    w24 = s24[23:0];
    got = 1'b0;
    for (int n = 0; n < 8 && !got; n++) begin
      @(negedge ap_clk);
      if (bus24.res_valid) got = 1'b1;
      else begin
        @(posedge ap_clk); #1;
      end
    end
    chk("wrap result seen", longint'(got), 1);
    if (got) begin
      chk("wrap res_data", longint'($signed(bus24.res_data)), longint'($signed(w24)));
      chk("wrap res_id", longint'(bus24.res_id), 0);
      @(posedge ap_clk); #1;
    end

    // Randomized traffic against the reference model.
    ap_rst        = 1'b1;
    bus.req_valid = '0;
    @(posedge ap_clk); #1;
    ap_rst = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) m_acc[i] = 0;
    m_pend_valid = 1'b0; m_res_valid = 1'b0; m_last = NUM_REQ - 1;
    m_pend_id = 0; m_pend_prod = 0; m_pend_last = 1'b0; m_res_sum = 0; m_res_id = 0;
    r_vld = '0; r_last = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      r_a[i] = '0; r_b[i] = '0;
    end

    for (int c = 0; c < 2000; c++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!r_vld[i] && $urandom_range(0, 9) < 6) begin
          r_vld[i]  = 1'b1;
          r_a[i]    = A_W'($urandom);
          r_b[i]    = B_W'($urandom);
          r_last[i] = ($urandom_range(0, 3) == 0);
        end
        bus.req_a[i*A_W +: A_W] = r_a[i];
        bus.req_b[i*B_W +: B_W] = r_b[i];
      end
      bus.req_valid = r_vld;
      bus.req_last  = r_last;
      bus.res_ready = ($urandom_range(0, 3) != 0);
      @(negedge ap_clk);

      stall = m_res_valid && !bus.res_ready;
      gnt   = -1;
      if (!stall) begin
        for (int off = 1; off <= NUM_REQ; off++) begin
          if (gnt < 0 && r_vld[(m_last + off) % NUM_REQ]) gnt = (m_last + off) % NUM_REQ;
        end
      end
      er = (gnt >= 0) ? 4'(1 << gnt) : 4'b0;
      chk($sformatf("rand%0d req_ready", c), longint'(bus.req_ready), longint'(er));
      chk($sformatf("rand%0d res_valid", c), longint'(bus.res_valid), longint'(m_res_valid));
      if (m_res_valid) begin
        w32 = m_res_sum[31:0];
        chk($sformatf("rand%0d res_data", c), longint'($signed(bus.res_data)),
            longint'($signed(w32)));
        chk($sformatf("rand%0d res_id", c), longint'(bus.res_id), longint'(m_res_id));
      end
      @(posedge ap_clk);

      if (!stall) begin
        m_res_valid = 1'b0;
        if (m_pend_valid) begin
          m_acc[m_pend_id] += m_pend_prod;
          if (m_pend_last) begin
            m_res_valid      = 1'b1;
            m_res_sum        = m_acc[m_pend_id];
            m_res_id         = m_pend_id;
            m_acc[m_pend_id] = 0;
          end
        end
        m_pend_valid = (gnt >= 0);
        if (gnt >= 0) begin
          m_pend_id   = gnt;
          m_pend_prod = longint'($signed(r_a[gnt])) * longint'($signed(r_b[gnt]));
          m_pend_last = r_last[gnt];
          m_last      = gnt;
          r_vld[gnt]  = 1'b0;
        end
      end
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
